// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler: latches floor requests and offers the next stop using a sweep (elevator) policy
// Ports: clk/rst (async, active-high); top_floor config; request_button[15:0] level requests;
//        current_floor/arrived from the car; target_valid/target_ready/target_floor offer handshake;
//        direction_up sweep direction; pending latched requests; busy = not IDLE.
module floor_request_scheduler #(
  parameter int DWELL_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  top_floor,
  input  logic [15:0] request_button,
  input  logic [3:0]  current_floor,
  input  logic        arrived,
  output logic        target_valid,
  input  logic        target_ready,
  output logic [3:0]  target_floor,
  output logic        direction_up,
  output logic [15:0] pending,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, SELECT, OFFER, MOVING, DWELL} state_t;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [15:0] r_pending;
  logic        r_valid;
  logic        r_dir;
  logic [3:0]  r_target;
  logic [15:0] w_mask;
  logic [15:0] w_clr;
  logic [15:0] w_pending_nxt;
  logic        w_up_found;
  logic        w_dn_found;
  logic [3:0]  w_up;
  logic [3:0]  w_dn;
  logic        w_here;
  logic        w_fwd;
  logic        w_sel_up;
  logic [3:0]  w_sel_t;
  logic        w_dir_nxt;
  // Descending scan leaves the lowest floor above; ascending scan leaves the highest floor below.
  always_comb begin
    w_mask     = '0;
    w_up_found = 1'b0;
    w_dn_found = 1'b0;
    w_up       = '0;
    w_dn       = '0;
    for (int i = 15; i >= 0; i--) begin
      w_mask[i] = i >= 1 && 4'(i) <= top_floor;
      if (r_pending[i] && 4'(i) > current_floor) begin
        w_up_found = 1'b1;
        w_up       = 4'(i);
      end
    end
    for (int i = 0; i < 16; i++)
      if (r_pending[i] && 4'(i) < current_floor) begin
        w_dn_found = 1'b1;
        w_dn       = 4'(i);
      end
  end
  // Clear is applied after set so an arrival wins over a same-cycle request.
  assign w_clr         = arrived ? 16'd1 << current_floor : '0;
  assign w_pending_nxt = (r_pending | (request_button & w_mask)) & ~w_clr & w_mask;
  // Head up when a forward candidate exists while going up, or none exists while going down.
  assign w_here    = r_pending[current_floor];
  assign w_fwd     = r_dir ? w_up_found : w_dn_found;
  assign w_sel_up  = w_here ? r_dir : ~(r_dir ^ w_fwd);
  assign w_sel_t   = w_here ? current_floor : w_sel_up ? w_up : w_dn;
  // Arrival at the end floors forces the sweep direction over any selection reversal.
  assign w_dir_nxt = (arrived && current_floor == top_floor) ? 1'b0 :
                     (arrived && current_floor == 4'd1) ? 1'b1 :
                     (r_state == SELECT && |r_pending) ? w_sel_up : r_dir;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_dir     <= 1'b1;
      r_target  <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_dir     <= w_dir_nxt;
      case (r_state)
        IDLE: if (|r_pending) r_state <= SELECT;
        SELECT:
          if (|r_pending) begin
            r_state  <= OFFER;
            r_target <= w_sel_t;
            r_valid  <= 1'b1;
          end else r_state <= IDLE;
        OFFER:
          if (target_ready) begin
            r_state <= MOVING;
            r_valid <= 1'b0;
          end
        MOVING:
          if (arrived && current_floor == r_target) begin
            r_state <= DWELL;
            r_cnt   <= 8'(DWELL_CYCLES - 1);
          end
        DWELL:
          if (r_cnt == 8'd0) begin
            if (|r_pending) r_state <= SELECT;
            else r_state <= IDLE;
          end else r_cnt <= r_cnt - 8'd1;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign target_valid = r_valid;
  assign target_floor = r_target;
  assign direction_up = r_dir;
  assign pending      = r_pending;
  assign busy         = r_state != IDLE;
endmodule

// File: tb/tb_floor_request_scheduler.sv
// tb_floor_request_scheduler: directed and randomized checks of the sweep scheduler against a floor-level model
module tb_floor_request_scheduler;
  localparam int D = 5;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  top_floor;
  logic [15:0] request_button;
  logic [3:0]  current_floor;
  logic        arrived;
  logic        target_valid;
  logic        target_ready;
  logic [3:0]  target_floor;
  logic        direction_up;
  logic [15:0] pending;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_pend;
  logic [15:0] p_pend;
  bit          m_dir;
  bit          p_dir;
  int          p_cf;
  int          exp_t;
  int          top;
  int          lat;
  int          f;
  bit          nd;
  bit          got;
  bit          idle0;
  bit          want;

  floor_request_scheduler #(.DWELL_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .top_floor(top_floor), .request_button(request_button),
    .current_floor(current_floor), .arrived(arrived), .target_valid(target_valid),
    .target_ready(target_ready), .target_floor(target_floor), .direction_up(direction_up),
    .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got_v, input logic [15:0] exp_v);
    checks++;
    assert (got_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Nearest pending floor by distance: current floor first, then the sweep side, else reverse.
  function automatic void sel(input logic [15:0] p, input int cf, input bit up, output int t, output bit ndir);
    int a = -1;
    int b = -1;
    if (p[cf]) begin
      t    = cf;
      ndir = up;
      return;
    end
    for (int d = 1; d < 16; d++) begin
      if (a < 0 && cf + d < 16 && p[cf + d]) a = cf + d;
      if (b < 0 && cf - d >= 0 && p[cf - d]) b = cf - d;
    end
    ndir = up ? (a >= 0) : !(b >= 0);
    t    = ndir ? a : b;
  endfunction

  // One clock: snapshot pre-edge model state, advance, apply floor rules, check pending, drop pulses.
  task automatic step();
    logic [15:0] np;
    p_pend = m_pend;
    p_cf   = int'(current_floor);
    p_dir  = m_dir;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++)
      np[k] = k >= 1 && k <= int'(top_floor) && !(arrived && int'(current_floor) == k) &&
              (m_pend[k] || request_button[k]);
    m_pend = np;
    if (arrived) m_dir = (current_floor == top_floor) ? 1'b0 : (current_floor == 4'd1) ? 1'b1 : m_dir;
    chk("pending", pending, m_pend);
    request_button = '0;
    arrived        = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst    = 1'b0;
    m_pend = '0;
    m_dir  = 1'b1;
  endtask

  initial begin
    rst = 1'b1; top_floor = '0; request_button = '0; current_floor = '0;
    arrived = 1'b0; target_ready = 1'b0; m_pend = '0; m_dir = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 16'(target_valid), 16'd0);
    chk("reset_target", 16'(target_floor), 16'd0);
    chk("reset_dir", 16'(direction_up), 16'd1);
    chk("reset_pending", pending, 16'd0);
    chk("reset_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    top_floor = 4'd4;
    repeat (3) begin
      request_button = 16'h0081;
      step();
      chk("ignored_busy", 16'(busy), 16'd0);
    end
    chk("ignored_pending", pending, 16'd0);
    top_floor = 4'd9; current_floor = 4'd2; request_button = 16'h0020;
    step();
    chk("latch", pending, 16'h0020);
    chk("latch_valid", 16'(target_valid), 16'd0);
    step();
    chk("select_valid", 16'(target_valid), 16'd0);
    chk("select_busy", 16'(busy), 16'd1);
    step();
    chk("offer_valid", 16'(target_valid), 16'd1);
    chk("offer_target", 16'(target_floor), 16'd5);
    chk("offer_dir", 16'(direction_up), 16'd1);
    repeat (10) begin
      step();
      chk("stall_valid", 16'(target_valid), 16'd1);
      chk("stall_target", 16'(target_floor), 16'd5);
    end
    target_ready = 1'b1;
    step();
    target_ready = 1'b0;
    chk("accept_valid", 16'(target_valid), 16'd0);
    chk("accept_busy", 16'(busy), 16'd1);
    current_floor = 4'd5; arrived = 1'b1; request_button = 16'h0020;
    step();
    chk("clear_wins", 16'(pending[5]), 16'd0);
    repeat (D - 1) step();
    chk("dwell_busy", 16'(busy), 16'd1);
    step();
    chk("dwell_idle", 16'(busy), 16'd0);
    current_floor = 4'd6; request_button = 16'h0108;
    repeat (3) step();
    chk("sweep_valid", 16'(target_valid), 16'd1);
    chk("sweep_target", 16'(target_floor), 16'd8);
    chk("sweep_dir", 16'(direction_up), 16'd1);
    target_ready = 1'b1;
    step();
    target_ready = 1'b0;
    current_floor = 4'd8; arrived = 1'b1;
    step();
    repeat (D) begin
      step();
      chk("sweep_dwell_valid", 16'(target_valid), 16'd0);
    end
    step();
    m_dir = 1'b0;
    chk("reverse_valid", 16'(target_valid), 16'd1);
    chk("reverse_target", 16'(target_floor), 16'd3);
    chk("reverse_dir", 16'(direction_up), 16'd0);
    rst = 1'b1;
    #1;
    chk("async_valid", 16'(target_valid), 16'd0);
    chk("async_pending", pending, 16'd0);
    chk("async_dir", 16'(direction_up), 16'd1);
    chk("async_busy", 16'(busy), 16'd0);
    #1;
    rst = 1'b0; m_pend = '0; m_dir = 1'b1;
    top_floor = 4'd9; current_floor = 4'd0; request_button = 16'h0104;
    step();
    chk("shrink_before", pending, 16'h0104);
    top_floor = 4'd5;
    step();
    chk("shrink_after", pending, 16'h0004);
    top_floor = 4'd0;
    step();
    chk("top_zero", pending, 16'd0);
    do_reset();
    top = $urandom_range(2, 15);
    top_floor = 4'(top);
    current_floor = 4'($urandom_range(0, top));
    for (int n = 0; n < 40; n++) begin
      got = target_valid;
      if (!target_valid) begin
        idle0 = !busy;
        request_button = 16'($urandom) & 16'($urandom);
        request_button[$urandom_range(1, top)] = 1'b1;
        lat = 0;
        while (!got && lat < 10) begin
          step();
          lat++;
          if (target_valid) begin
            got = 1'b1;
            sel(p_pend, p_cf, p_dir, exp_t, nd);
            m_dir = nd;
          end
        end
        chk("offer_seen", 16'(got), 16'd1);
        if (idle0) chk("req_to_offer", 16'(lat), 16'd3);
      end
      if (!got) do_reset();
      else begin
        chk("rand_target", 16'(target_floor), 16'(exp_t));
        chk("rand_dir", 16'(direction_up), 16'(m_dir));
        repeat ($urandom_range(0, 3)) begin
          step();
          chk("rand_hold_valid", 16'(target_valid), 16'd1);
          chk("rand_hold_target", 16'(target_floor), 16'(exp_t));
        end
        target_ready = 1'b1;
        step();
        target_ready = 1'b0;
        chk("rand_accept", 16'(target_valid), 16'd0);
        repeat ($urandom_range(0, 2)) begin
          f = $urandom_range(0, 15);
          if (f == exp_t) f = (f + 1) % 16;
          current_floor = 4'(f); arrived = 1'b1;
          request_button = 16'($urandom) & 16'($urandom) & 16'($urandom);
          step();
          chk("pass_valid", 16'(target_valid), 16'd0);
          chk("pass_busy", 16'(busy), 16'd1);
          chk("pass_dir", 16'(direction_up), 16'(m_dir));
        end
        current_floor = 4'(exp_t); arrived = 1'b1;
        step();
        chk("arrive_dir", 16'(direction_up), 16'(m_dir));
        want = 1'b0;
        for (int k = 1; k <= D; k++) begin
          want = m_pend != 0;
          step();
          chk("rand_dwell_valid", 16'(target_valid), 16'd0);
          chk("rand_dwell_busy", 16'(busy), k < D ? 16'd1 : 16'(want));
        end
        if (want) begin
          step();
          sel(p_pend, p_cf, p_dir, exp_t, nd);
          m_dir = nd;
          chk("next_offer", 16'(target_valid), 16'd1);
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/floor_request_scheduler.md
FLOOR_REQUEST_SCHEDULER -- requirements
Module: floor_request_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 8: cycles the scheduler holds after an arrival before it selects the next target (range 1..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 top_floor  input  4  highest serviceable floor (configuration value).
REQ-005 request_button  input  16  level request per floor; bit i = floor i.
REQ-006 current_floor  input  4  floor the car is at or passing.
REQ-007 arrived  input  1  one-cycle pulse: car stopped and doors open at current_floor.
REQ-008 target_valid  output  1  target_floor offer is valid.
REQ-009 target_ready  input  1  motion controller accepts the offered target.
REQ-010 target_floor  output  4  floor selected for the next stop.
REQ-011 direction_up  output  1  current sweep direction; 1=up, 0=down.
REQ-012 pending  output  16  latched outstanding requests.
REQ-013 busy  output  1  high whenever state != IDLE.

Function
REQ-014 Pending latch: bit i sets when request_button[i]=1, 1<=i<=top_floor; floor 0 and floors above top_floor are never latched.
REQ-015 Pending clear: bit i clears in the cycle after arrived=1 with current_floor==i; clear wins over a same-cycle set of the same bit.
REQ-016 If top_floor decreases, bits above the new top_floor clear on the next clock edge.
REQ-017 FSM states: IDLE, SELECT, OFFER, MOVING, DWELL.
REQ-018 IDLE -> SELECT when pending != 0; otherwise stay in IDLE.
REQ-019 SELECT lasts exactly one cycle and then moves to OFFER, latching target_floor per REQ-020..022.
REQ-020 Selection priority 1: pending[current_floor]=1 -> target = current_floor.
REQ-021 Selection priority 2: if direction_up, target = lowest pending floor > current_floor; else target = highest pending floor < current_floor.
REQ-022 Selection priority 3: if no candidate exists in the sweep direction, direction_up toggles in the same cycle and the nearest pending floor in the opposite direction is chosen.
REQ-023 If pending becomes 0 while in SELECT, the FSM returns to IDLE with no offer.
REQ-024 OFFER: target_valid=1; target_floor is held stable until target_valid & target_ready; the FSM then moves to MOVING and target_valid drops the following cycle.
REQ-025 MOVING: arrived with current_floor==target_floor -> DWELL with the counter loaded to DWELL_CYCLES-1.
REQ-026 MOVING: arrived at any other floor clears that floor's pending bit (REQ-015) and causes no state change.
REQ-027 DWELL: the counter decrements each cycle; at 0 the FSM goes to SELECT if pending != 0, else to IDLE.
REQ-028 direction_up forces to 0 on arrival at top_floor and to 1 on arrival at floor 1, overriding REQ-022 in that cycle.
REQ-029 top_floor==0: all requests are ignored, and the FSM stays in or returns to IDLE after any in-flight dwell completes.
REQ-030 Arrival-to-next-offer latency = DWELL_CYCLES + 1 (SELECT) cycles; request-to-offer latency from IDLE = 3 cycles (latch, IDLE->SELECT, SELECT->OFFER).

Reset
REQ-031 Reset asserted: state=IDLE, pending=0, target_valid=0, target_floor=0, direction_up=1, busy=0, dwell counter=0.
REQ-032 Reset asserted mid-operation (any state) takes effect immediately and discards the in-flight offer and all pending requests.
REQ-033 First valid edge after reset deassertion evaluates inputs normally.

Verification
REQ-034 top_floor=9, current_floor=2, request_button[5] pulsed 1 cycle -> pending=0x0020, target_valid high 3 cycles later with target_floor=5, direction_up=1.
REQ-035 Offer target 5, target_ready held 0 for 10 cycles -> target_valid and target_floor=5 stay stable throughout; ready=1 -> state MOVING, target_valid=0 the next cycle.
REQ-036 direction_up=1, current_floor=6, pending={3,8} -> target 8; after arrival at 8 and a dwell of DWELL_CYCLES, target 3 with direction_up=0.
REQ-037 top_floor=4, request_button[7] and request_button[0] asserted -> pending stays 0, busy stays 0.
REQ-038 Same-cycle arrived at floor 5 and request_button[5]=1 -> pending[5]=0 the next cycle.
REQ-039 rst asserted while in OFFER -> target_valid=0, pending=0, direction_up=1 asynchronously, before the next clock edge.
